// File: rtl/key_pulse_gen.sv
// Mechanical key press generator: produces a timed key level with optional
// contact chatter on press and release, plus light/busy/done status outputs.
module key_pulse_gen #(
    parameter int TICK_DIV   = 100000,
    parameter int BOUNCE_CYC = 8,
    parameter int BOUNCE_LEN = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dur,
    input  logic        bounce_en,
    input  logic        abort,
    output logic        key,
    output logic        light,
    output logic        busy,
    output logic        done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;
    localparam int CW = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LEN_LAST   = LW'(BOUNCE_LEN - 1);
    localparam logic [CW-1:0] CYC_LAST   = CW'(BOUNCE_CYC - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BOUNCE_DN = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;
    localparam logic [1:0] ST_BOUNCE_UP = 2'd3;

    logic [1:0]    state, state_n;
    logic          key_n, light_n, busy_n, done_n;
    logic [PW-1:0] presc, presc_n;
    logic [15:0]   ticks, ticks_n;
    logic [LW-1:0] bcnt, bcnt_n;
    logic [CW-1:0] bhalf, bhalf_n;
    logic [15:0]   dur_q, dur_n;
    logic          bounce_q, bounce_n;
    logic          half_end;

    assign half_end = (bcnt == LEN_LAST);

    // Hold time is a prescaler nested inside a tick counter, so the full
    // dur*TICK_DIV product never has to exist in one register.
    always_comb begin
        state_n  = state;
        key_n    = key;
        light_n  = light;
        busy_n   = busy;
        done_n   = 1'b0;
        presc_n  = presc;
        ticks_n  = ticks;
        bcnt_n   = bcnt;
        bhalf_n  = bhalf;
        dur_n    = dur_q;
        bounce_n = bounce_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    dur_n    = dur;
                    bounce_n = bounce_en;
                    presc_n  = '0;
                    ticks_n  = '0;
                    bcnt_n   = '0;
                    bhalf_n  = '0;
                    if (dur == 16'd0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = bounce_en ? ST_BOUNCE_DN : ST_HOLD;
                        key_n   = 1'b1;
                        light_n = 1'b1;
                        busy_n  = 1'b1;
                    end
                end
            end

            ST_BOUNCE_DN: begin
                if (half_end) begin
                    bcnt_n = '0;
                    if (bhalf == CYC_LAST) begin
                        state_n = ST_HOLD;
                        key_n   = 1'b1;
                        bhalf_n = '0;
                    end else begin
                        bhalf_n = bhalf + CW'(1);
                        key_n   = bhalf[0];
                    end
                end else begin
                    bcnt_n = bcnt + LW'(1);
                end
            end

            ST_HOLD: begin
                if (presc == PRESC_LAST) begin
                    presc_n = '0;
                    if (ticks == dur_q - 16'd1) begin
                        bcnt_n  = '0;
                        bhalf_n = '0;
                        if (bounce_q) begin
                            state_n = ST_BOUNCE_UP;
                            key_n   = 1'b0;
                        end else begin
                            state_n = ST_IDLE;
                            key_n   = 1'b0;
                            light_n = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        ticks_n = ticks + 16'd1;
                    end
                end else begin
                    presc_n = presc + PW'(1);
                end
            end

            ST_BOUNCE_UP: begin
                if (half_end) begin
                    bcnt_n = '0;
                    if (bhalf == CYC_LAST) begin
                        state_n = ST_IDLE;
                        bhalf_n = '0;
                        key_n   = 1'b0;
                        light_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        bhalf_n = bhalf + CW'(1);
                        key_n   = ~bhalf[0];
                    end
                end else begin
                    bcnt_n = bcnt + LW'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
                key_n   = 1'b0;
                light_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase

        // Cancelling overrides whatever the state machine decided this cycle.
        if (abort && (state != ST_IDLE)) begin
            state_n = ST_IDLE;
            key_n   = 1'b0;
            light_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            key      <= 1'b0;
            light    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            presc    <= '0;
            ticks    <= '0;
            bcnt     <= '0;
            bhalf    <= '0;
            dur_q    <= '0;
            bounce_q <= 1'b0;
        end else begin
            state    <= state_n;
            key      <= key_n;
            light    <= light_n;
            busy     <= busy_n;
            done     <= done_n;
            presc    <= presc_n;
            ticks    <= ticks_n;
            bcnt     <= bcnt_n;
            bhalf    <= bhalf_n;
            dur_q    <= dur_n;
            bounce_q <= bounce_n;
        end
    end

endmodule
